// File: rtl/edge_pkg.sv
// edge_pkg
// Shared definitions for the sliding-window stream buffer:
//   - wsb_state_e : frame-tracking FSM states
//   - k_is_legal  : window sizes the datapath supports (3 or 5)
//   - idx_w       : index width for a counter or address over n entries
//   - MAX_DIM     : largest supported line length / frame height
package edge_pkg;

   // Frame tracking:
   // IDLE until the first start-of-frame, FILL while the line stores are
   // priming, RUN while windows are produced, DONE after the last pixel.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } wsb_state_e;

   localparam int MAX_DIM = 4096;

   // Only odd window sizes with a well-defined centre are built.
   function automatic bit k_is_legal(input int k);
      return (k == 3) || (k == 5);
   endfunction

   // Width of an index over n entries, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/line_ram.sv
// line_ram
// One line of pixel history. Single port: the same address is read and
// written in a cycle, and the read returns the contents from before the
// write, so a cascade of these acts as a set of line delays.
// Ports:
//   clk   : clock, rising edge
//   we    : write enable
//   addr  : column address (0 .. DEPTH-1)
//   wdata : pixel written at addr when we is high
//   rdata : pixel stored at addr before this cycle's write
module line_ram
   import edge_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int WIDTH = 8,
   parameter int AW    = idx_w(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately not reset; stale data is never used
   // because windows only appear once a frame has primed every line.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Read path is combinational, so the old word is visible in the same
   // cycle that the new word is being written.
   assign rdata = mem[addr];

endmodule

// File: rtl/window_stream_buffer.sv
// window_stream_buffer
// Turns a raster pixel stream into K x K neighbourhood windows without
// border padding: one window per accepted pixel at row >= K-1 and
// col >= K-1, i.e. (IMG_W-K+1)*(IMG_H-K+1) windows per frame.
// K-1 line stores hold previous lines; a K-column shift register holds
// the window itself and is driven straight out as m_win.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   s_valid/s_ready     : input pixel handshake
//   s_data, s_sof       : pixel, and start-of-frame qualifier
//   m_valid/m_ready     : output window handshake
//   m_win               : window, row r / column c at PIX_W*(r*K+c)
//   m_eol, m_eof        : last window of an output line / of the frame
//   sof_err             : sticky start-of-frame protocol error
// Build option:
//   WSB_SOF_RESYNC_EN   : a start-of-frame seen mid-frame aborts the frame
//                         and restarts at that pixel; otherwise it is
//                         flagged and ignored.
module window_stream_buffer
   import edge_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int K     = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [PIX_W-1:0]     s_data,
   input  logic                 s_sof,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [K*K*PIX_W-1:0] m_win,
   output logic                 m_eol,
   output logic                 m_eof,
   output logic                 sof_err
);

   localparam int COL_W = idx_w(IMG_W);
   localparam int ROW_W = idx_w(IMG_H);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_KM1  = COL_W'(K - 1);
   localparam logic [ROW_W-1:0] ROW_KM1  = ROW_W'(K - 1);

   // Elaboration guards on the geometry.
   if (!k_is_legal(K)) begin : g_bad_k
      $error("window_stream_buffer: K must be 3 or 5");
   end
   if (IMG_W < K || IMG_W > MAX_DIM || IMG_H < K || IMG_H > MAX_DIM) begin : g_bad_dim
      $error("window_stream_buffer: IMG_W/IMG_H out of range");
   end

   wsb_state_e       state_q, state_d;
   logic [COL_W-1:0] col_q, col_d, pos_col;
   logic [ROW_W-1:0] row_q, row_d, pos_row;
   logic             s_fire;
   logic             frame_active;
   logic             emit;
   logic             err_set;
   logic             line_end;
   logic             last_pix;
   logic             frame_seen_q;

   logic [PIX_W-1:0] lb_rdata [K-1];
   logic [PIX_W-1:0] lb_wdata [K-1];
   logic [PIX_W-1:0] col_vec  [K];
   logic [PIX_W-1:0] win_q    [K][K];

   // A new pixel can be taken whenever there is no window, or the
   // pending window leaves this cycle.
   assign s_ready = !m_valid || m_ready;
   assign s_fire  = s_valid && s_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, raster position of the pixel being accepted, and what
   // that pixel produces. pos_row/pos_col is where this pixel lands in
   // the frame: the counters normally, or the origin for a frame start.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      pos_col      = col_q;
      pos_row      = row_q;
      frame_active = 1'b0;
      emit         = 1'b0;
      err_set      = 1'b0;
      line_end     = 1'b0;
      last_pix     = 1'b0;

      if (s_fire) begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (s_sof) begin
                  frame_active = 1'b1;
                  pos_col      = '0;
                  pos_row      = '0;
               end else if (state_q == ST_IDLE && frame_seen_q) begin
                  err_set = 1'b1;
               end
            end
            ST_FILL, ST_RUN: begin
               frame_active = 1'b1;
               if (s_sof) begin
                  err_set = 1'b1;
`ifdef WSB_SOF_RESYNC_EN
                  pos_col = '0;
                  pos_row = '0;
`endif
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

         if (frame_active) begin
            line_end = (pos_col == COL_LAST);
            last_pix = line_end && (pos_row == ROW_LAST);
            emit     = (pos_row >= ROW_KM1) && (pos_col >= COL_KM1);
            if (last_pix) begin
               state_d = ST_DONE;
               col_d   = '0;
               row_d   = '0;
            end else begin
               if (line_end) begin
                  col_d = '0;
                  row_d = pos_row + ROW_W'(1);
               end else begin
                  col_d = pos_col + COL_W'(1);
                  row_d = pos_row;
               end
               state_d = (row_d >= ROW_KM1) ? ST_RUN : ST_FILL;
            end
         end
      end
   end

   // Position counters, sticky error and output handshake flags. The
   // window flags only change when a pixel is taken, which cannot happen
   // while a window is stalled, so they hold under back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         frame_seen_q <= 1'b0;
         sof_err      <= 1'b0;
         m_valid      <= 1'b0;
         m_eol        <= 1'b0;
         m_eof        <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         if (frame_active) begin
            frame_seen_q <= 1'b1;
         end
         if (err_set) begin
            sof_err <= 1'b1;
         end
         if (s_fire) begin
            m_valid <= emit;
            m_eol   <= emit && line_end;
            m_eof   <= emit && last_pix;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   // Line store cascade: store 0 holds the previous line, store j the
   // line j+1 back. Each store receives what the one above it returned.
   for (genvar j = 0; j < K - 1; j++) begin : g_line
      if (j == 0) begin : g_head
         assign lb_wdata[j] = s_data;
      end else begin : g_tail
         assign lb_wdata[j] = lb_rdata[j-1];
      end
      line_ram #(
         .DEPTH (IMG_W),
         .WIDTH (PIX_W),
         .AW    (COL_W)
      ) u_line (
         .clk   (clk),
         .we    (frame_active),
         .addr  (pos_col),
         .wdata (lb_wdata[j]),
         .rdata (lb_rdata[j])
      );
   end

   // Incoming window column, top (oldest line) first, current pixel last.
   for (genvar r = 0; r < K - 1; r++) begin : g_colvec
      assign col_vec[r] = lb_rdata[K-2-r];
   end
   assign col_vec[K-1] = s_data;

   // Window shift register: columns move left, the new column enters on
   // the right. Shifting happens for every in-frame pixel so the window
   // is always complete by the time one is emitted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else if (frame_active) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               win_q[r][c] <= win_q[r][c+1];
            end
            win_q[r][K-1] <= col_vec[r];
         end
      end
   end

   for (genvar r = 0; r < K; r++) begin : g_pack_r
      for (genvar c = 0; c < K; c++) begin : g_pack_c
         assign m_win[PIX_W*(r*K+c) +: PIX_W] = win_q[r][c];
      end
   end

endmodule

// File: tb/tb_window_stream_buffer.sv
// tb_window_stream_buffer
// Drives an 8x6 frame geometry into a K=3 and a K=5 instance. Pixels are
// queued per instance; expected windows are computed from the frame image
// and queued as the frame is queued, then compared against the windows the
// instance hands over.
module tb_window_stream_buffer;

   logic         clk = 1'b0;
   logic         rst_n;

   logic         s_valid3, s_ready3, s_sof3, m_valid3, m_ready3, m_eol3, m_eof3, sof_err3;
   logic [7:0]   s_data3;
   logic [71:0]  m_win3;
   logic         s_valid5, s_ready5, s_sof5, m_valid5, m_ready5, m_eol5, m_eof5, sof_err5;
   logic [7:0]   s_data5;
   logic [199:0] m_win5;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [8:0]   src3 [$];
   logic [8:0]   src5 [$];
   logic [73:0]  exp3 [$];
   logic [73:0]  obs3 [$];
   logic [201:0] exp5 [$];
   logic [201:0] obs5 [$];
   logic [7:0]   img  [48];
   int           acc3, acc5, first_acc3;

   always #5 clk = ~clk;

   window_stream_buffer #(.PIX_W(8), .IMG_W(8), .IMG_H(6), .K(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
      .s_sof(s_sof3), .m_valid(m_valid3), .m_ready(m_ready3), .m_win(m_win3),
      .m_eol(m_eol3), .m_eof(m_eof3), .sof_err(sof_err3));

   window_stream_buffer #(.PIX_W(8), .IMG_W(8), .IMG_H(6), .K(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5),
      .s_sof(s_sof5), .m_valid(m_valid5), .m_ready(m_ready5), .m_win(m_win5),
      .m_eol(m_eol5), .m_eof(m_eof5), .sof_err(sof_err5));

   // One clock: drive from the queues, sample both instances on the
   // falling edge, then return just after the next rising edge.
   task automatic step(input bit v3, input bit r3, input bit v5, input bit r5);
      s_valid3 = v3 && (src3.size() > 0);
      s_sof3   = s_valid3 ? src3[0][8] : 1'b0;
      s_data3  = s_valid3 ? src3[0][7:0] : 8'h00;
      m_ready3 = r3;
      s_valid5 = v5 && (src5.size() > 0);
      s_sof5   = s_valid5 ? src5[0][8] : 1'b0;
      s_data5  = s_valid5 ? src5[0][7:0] : 8'h00;
      m_ready5 = r5;
      @(negedge clk);
      if (m_valid3 && first_acc3 < 0) first_acc3 = acc3;
      if (m_valid3 && m_ready3) obs3.push_back({m_eof3, m_eol3, m_win3});
      if (s_valid3 && s_ready3) begin void'(src3.pop_front()); acc3++; end
      if (m_valid5 && m_ready5) obs5.push_back({m_eof5, m_eol5, m_win5});
      if (s_valid5 && s_ready5) begin void'(src5.pop_front()); acc5++; end
      @(posedge clk);
      #1;
   endtask

   task automatic fill_img(input int mode);
      for (int i = 0; i < 48; i++) begin
         case (mode)
            0:       img[i] = 8'(i);
            1:       img[i] = 8'($urandom_range(0, 255));
            default: img[i] = 8'(100 + i);
         endcase
      end
   endtask

   task automatic push_pix3(input int first, input int last);
      for (int i = first; i <= last; i++) src3.push_back({(i == 0), img[i]});
   endtask

   task automatic push_pix5(input int first, input int last);
      for (int i = first; i <= last; i++) src5.push_back({(i == 0), img[i]});
   endtask

   // Reference windows of img whose bottom-right pixel index is < limit.
   task automatic expect3(input int limit);
      logic [73:0] w;
      for (int r = 2; r < 6; r++) for (int c = 2; c < 8; c++) if (r * 8 + c < limit) begin
         w = '0;
         for (int rr = 0; rr < 3; rr++) for (int cc = 0; cc < 3; cc++)
            w[8*(rr*3+cc) +: 8] = img[(r-2+rr)*8 + (c-2+cc)];
         w[72] = (c == 7);
         w[73] = (r == 5) && (c == 7);
         exp3.push_back(w);
      end
   endtask

   task automatic expect5(input int limit);
      logic [201:0] w;
      for (int r = 4; r < 6; r++) for (int c = 4; c < 8; c++) if (r * 8 + c < limit) begin
         w = '0;
         for (int rr = 0; rr < 5; rr++) for (int cc = 0; cc < 5; cc++)
            w[8*(rr*5+cc) +: 8] = img[(r-4+rr)*8 + (c-4+cc)];
         w[200] = (c == 7);
         w[201] = (r == 5) && (c == 7);
         exp5.push_back(w);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      tests_run++;
      if ({m_valid3, m_eol3, m_eof3, sof_err3} !== 4'b0) begin
         tests_failed++; $display("[TB] FAIL reset_flags3 got %b expected 0000", {m_valid3, m_eol3, m_eof3, sof_err3});
      end
      tests_run++;
      if (m_win3 !== '0) begin tests_failed++; $display("[TB] FAIL reset_win3 got %h expected 0", m_win3); end
      tests_run++;
      if ({m_valid5, m_eol5, m_eof5, sof_err5} !== 4'b0) begin
         tests_failed++; $display("[TB] FAIL reset_flags5 got %b expected 0000", {m_valid5, m_eol5, m_eof5, sof_err5});
      end
      tests_run++;
      if (m_win5 !== '0) begin tests_failed++; $display("[TB] FAIL reset_win5 got %h expected 0", m_win5); end
      tests_run++;
      if (s_ready3 !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready got %b expected 1", s_ready3); end
      rst_n = 1'b1;
      step(0, 1, 0, 1);
   endtask

   task automatic test_first_frame;
      int cyc, n;
      logic [73:0] got, want;
      // Pixels without start-of-frame before any frame are dropped quietly.
      src3.push_back(9'h0AA); src3.push_back(9'h055); src3.push_back(9'h0F0);
      cyc = 0;
      while (src3.size() > 0 && cyc < 50) begin step(1, 1, 0, 1); cyc++; end
      step(0, 1, 0, 1);
      tests_run++;
      if ({m_valid3, sof_err3, 1'(src3.size() == 0)} !== 3'b001) begin
         tests_failed++; $display("[TB] FAIL idle_discard got valid/err/drained %b expected 001", {m_valid3, sof_err3, 1'(src3.size() == 0)});
      end
      acc3 = 0; first_acc3 = -1;
      fill_img(0); push_pix3(0, 47); expect3(48);
      cyc = 0;
      while ((src3.size() > 0 || obs3.size() < exp3.size()) && cyc < 1000) begin step(1, 1, 0, 1); cyc++; end
      for (int i = 0; i < 5; i++) step(1, 1, 0, 1);
      tests_run++;
      if (first_acc3 !== 19) begin tests_failed++; $display("[TB] FAIL first_window_accepts got %0d expected 19", first_acc3); end
      n = 0;
      while (obs3.size() > 0 && exp3.size() > 0) begin
         got = obs3.pop_front(); want = exp3.pop_front(); n++;
         tests_run++;
         if (got !== want) begin tests_failed++; $display("[TB] FAIL frame_window %0d got %h expected %h", n, got, want); end
      end
      tests_run++;
      if (n + obs3.size() !== 24) begin tests_failed++; $display("[TB] FAIL frame_count got %0d expected 24", n + obs3.size()); end
      obs3.delete(); exp3.delete();
   endtask

   task automatic test_backpressure;
      int cyc, n;
      logic [71:0] held;
      logic [73:0] got, want;
      fill_img(0); push_pix3(0, 47); expect3(48);
      cyc = 0;
      while (!(obs3.size() >= 2 && m_valid3) && cyc < 200) begin step(1, 1, 0, 1); cyc++; end
      tests_run++;
      if (cyc >= 200) begin tests_failed++; $display("[TB] FAIL stall_setup got timeout expected window"); end
      held = m_win3;
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 1);
         tests_run++;
         if (s_ready3 !== 1'b0 || m_valid3 !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL stall_ready cycle %0d got ready/valid %b%b expected 01", i, s_ready3, m_valid3);
         end
         tests_run++;
         if (m_win3 !== held) begin tests_failed++; $display("[TB] FAIL stall_hold cycle %0d got %h expected %h", i, m_win3, held); end
      end
      cyc = 0;
      while ((src3.size() > 0 || obs3.size() < exp3.size()) && cyc < 1000) begin step(1, 1, 0, 1); cyc++; end
      for (int i = 0; i < 5; i++) step(1, 1, 0, 1);
      n = 0;
      while (obs3.size() > 0 && exp3.size() > 0) begin
         got = obs3.pop_front(); want = exp3.pop_front(); n++;
         tests_run++;
         if (got !== want) begin tests_failed++; $display("[TB] FAIL stall_window %0d got %h expected %h", n, got, want); end
      end
      tests_run++;
      if (n + obs3.size() !== 24) begin tests_failed++; $display("[TB] FAIL stall_count got %0d expected 24", n + obs3.size()); end
      obs3.delete(); exp3.delete();
   endtask

   task automatic test_k5;
      int cyc, n;
      logic [201:0] got, want;
      fill_img(0); push_pix5(0, 47); expect5(48);
      cyc = 0;
      while ((src5.size() > 0 || obs5.size() < exp5.size()) && cyc < 1000) begin step(0, 1, 1, 1); cyc++; end
      for (int i = 0; i < 5; i++) step(0, 1, 1, 1);
      got = (obs5.size() > 0) ? obs5[0] : '0;
      tests_run++;
      if ({got[7:0], got[39:32], got[167:160], got[199:192]} !== {8'd0, 8'd4, 8'd32, 8'd36}) begin
         tests_failed++; $display("[TB] FAIL k5_corners got %h expected 00042024", {got[7:0], got[39:32], got[167:160], got[199:192]});
      end
      n = 0;
      while (obs5.size() > 0 && exp5.size() > 0) begin
         got = obs5.pop_front(); want = exp5.pop_front(); n++;
         tests_run++;
         if (got !== want) begin tests_failed++; $display("[TB] FAIL k5_window %0d got %h expected %h", n, got, want); end
      end
      tests_run++;
      if (n + obs5.size() !== 8) begin tests_failed++; $display("[TB] FAIL k5_count got %0d expected 8", n + obs5.size()); end
      obs5.delete(); exp5.delete();
   endtask

   task automatic test_reset_mid_frame;
      int cyc, n;
      logic [73:0] got, want;
      acc3 = 0;
      fill_img(0); push_pix3(0, 47); expect3(48);
      cyc = 0;
      while (acc3 < 30 && cyc < 200) begin step(1, 1, 0, 1); cyc++; end
      while (obs3.size() > 0 && exp3.size() > 0) begin
         got = obs3.pop_front(); want = exp3.pop_front();
         tests_run++;
         if (got !== want) begin tests_failed++; $display("[TB] FAIL prereset_window got %h expected %h", got, want); end
      end
      rst_n = 1'b0;
      src3.delete(); exp3.delete(); obs3.delete();
      step(1, 1, 0, 1);
      tests_run++;
      if ({m_valid3, m_eol3, m_eof3, sof_err3, 1'(m_win3 == '0)} !== 5'b00001) begin
         tests_failed++; $display("[TB] FAIL midreset_outputs got %b expected 00001", {m_valid3, m_eol3, m_eof3, sof_err3, 1'(m_win3 == '0)});
      end
      rst_n = 1'b1;
      step(0, 1, 0, 1);
      fill_img(0); push_pix3(0, 47); expect3(48);
      cyc = 0;
      while ((src3.size() > 0 || obs3.size() < exp3.size()) && cyc < 1000) begin step(1, 1, 0, 1); cyc++; end
      for (int i = 0; i < 5; i++) step(1, 1, 0, 1);
      n = 0;
      while (obs3.size() > 0 && exp3.size() > 0) begin
         got = obs3.pop_front(); want = exp3.pop_front(); n++;
         tests_run++;
         if (got !== want) begin tests_failed++; $display("[TB] FAIL postreset_window %0d got %h expected %h", n, got, want); end
      end
      tests_run++;
      if (n + obs3.size() !== 24) begin tests_failed++; $display("[TB] FAIL postreset_count got %0d expected 24", n + obs3.size()); end
      obs3.delete(); exp3.delete();
   endtask

   task automatic test_random;
      int cyc, n3, n5;
      logic [73:0]  got3, want3;
      logic [201:0] got5, want5;
      for (int f = 0; f < 3; f++) begin
         fill_img(1);
         push_pix3(0, 47); expect3(48);
         push_pix5(0, 47); expect5(48);
      end
      cyc = 0;
      while ((src3.size() > 0 || src5.size() > 0 || obs3.size() < exp3.size() || obs5.size() < exp5.size())
             && cyc < 8000) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         cyc++;
      end
      for (int i = 0; i < 10; i++) step(1, 1, 1, 1);
      n3 = 0;
      while (obs3.size() > 0 && exp3.size() > 0) begin
         got3 = obs3.pop_front(); want3 = exp3.pop_front(); n3++;
         tests_run++;
         if (got3 !== want3) begin tests_failed++; $display("[TB] FAIL random3_window %0d got %h expected %h", n3, got3, want3); end
      end
      n5 = 0;
      while (obs5.size() > 0 && exp5.size() > 0) begin
         got5 = obs5.pop_front(); want5 = exp5.pop_front(); n5++;
         tests_run++;
         if (got5 !== want5) begin tests_failed++; $display("[TB] FAIL random5_window %0d got %h expected %h", n5, got5, want5); end
      end
      tests_run++;
      if (n3 + obs3.size() !== 72 || n5 + obs5.size() !== 24) begin
         tests_failed++; $display("[TB] FAIL random_count got %0d/%0d expected 72/24", n3 + obs3.size(), n5 + obs5.size());
      end
      obs3.delete(); exp3.delete(); obs5.delete(); exp5.delete();
   endtask

   task automatic test_sof_midframe;
      int cyc, n;
      logic [73:0] got, want;
      tests_run++;
      if (sof_err3 !== 1'b0) begin tests_failed++; $display("[TB] FAIL sof_err_before got %b expected 0", sof_err3); end
      fill_img(0); push_pix3(0, 19);
`ifdef WSB_SOF_RESYNC_EN
      expect3(20);
      fill_img(2); push_pix3(0, 47); expect3(48);
`else
      fill_img(2); push_pix3(0, 47);
      for (int i = 0; i < 48; i++) img[i] = (i < 20) ? 8'(i) : 8'(100 + i - 20);
      expect3(48);
`endif
      cyc = 0;
      while ((src3.size() > 0 || obs3.size() < exp3.size()) && cyc < 1000) begin step(1, 1, 0, 1); cyc++; end
      for (int i = 0; i < 5; i++) step(1, 1, 0, 1);
      n = 0;
      while (obs3.size() > 0 && exp3.size() > 0) begin
         got = obs3.pop_front(); want = exp3.pop_front(); n++;
         tests_run++;
         if (got !== want) begin tests_failed++; $display("[TB] FAIL sof_window %0d got %h expected %h", n, got, want); end
      end
      tests_run++;
`ifdef WSB_SOF_RESYNC_EN
      if (n + obs3.size() !== 26) begin tests_failed++; $display("[TB] FAIL sof_count got %0d expected 26", n + obs3.size()); end
`else
      if (n + obs3.size() !== 24) begin tests_failed++; $display("[TB] FAIL sof_count got %0d expected 24", n + obs3.size()); end
`endif
      tests_run++;
      if (sof_err3 !== 1'b1) begin tests_failed++; $display("[TB] FAIL sof_err_set got %b expected 1", sof_err3); end
      step(0, 1, 0, 1);
      tests_run++;
      if (sof_err3 !== 1'b1) begin tests_failed++; $display("[TB] FAIL sof_err_sticky got %b expected 1", sof_err3); end
      rst_n = 1'b0;
      step(0, 1, 0, 1);
      rst_n = 1'b1;
      step(0, 1, 0, 1);
      tests_run++;
      if (sof_err3 !== 1'b0) begin tests_failed++; $display("[TB] FAIL sof_err_clear got %b expected 0", sof_err3); end
      obs3.delete(); exp3.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      s_valid3 = 1'b0; s_sof3 = 1'b0; s_data3 = 8'h00; m_ready3 = 1'b1;
      s_valid5 = 1'b0; s_sof5 = 1'b0; s_data5 = 8'h00; m_ready5 = 1'b1;
      acc3 = 0; acc5 = 0; first_acc3 = -1;
      @(posedge clk);
      #1;
      test_reset();
      test_first_frame();
      test_backpressure();
      test_k5();
      test_reset_mid_frame();
      test_random();
      test_sof_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/window_stream_buffer.md
WINDOW_STREAM_BUFFER -- requirements
Module: window_stream_buffer

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 640, pixels per line (K..4096).
REQ-003 SHALL have parameter IMG_H, default 480, lines per frame (K..4096).
REQ-004 SHALL have parameter K, default 3, window size; only 3 or 5 are legal, and any other value is a elaboration error.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port s_valid  in  1  input pixel valid.
REQ-008 SHALL have port s_ready  out  1  input pixel accepted when s_valid&&s_ready.
REQ-009 SHALL have port s_data  in  PIX_W  grayscale pixel, raster order.
REQ-010 SHALL have port s_sof  in  1  qualifies s_data as first pixel of a frame.
REQ-011 SHALL have port m_valid  out  1  window valid.
REQ-012 SHALL have port m_ready  in  1  downstream accepts window.
REQ-013 SHALL have port m_win  out  K*K*PIX_W  window; slice [PIX_W*(r*K+c) +: PIX_W] is row r (0 = top/oldest) and column c (0 = left).
REQ-014 SHALL have port m_eol  out  1  window is the last one of its output line.
REQ-015 SHALL have port m_eof  out  1  window is the last one of the frame.
REQ-016 SHALL have port sof_err  out  1  sticky flag: protocol error seen.

Function
REQ-017 SHALL store K-1 previous lines plus a K-column shift window; a window centred at (row-(K-1)/2, col-(K-1)/2) is formed when the accepted pixel has row>=K-1 and col>=K-1.
REQ-018 SHALL emit exactly (IMG_W-K+1)*(IMG_H-K+1) windows per frame, with no border padding.
REQ-019 SHALL register outputs: m_valid rises in the cycle after the completing input handshake.
REQ-020 SHALL drive s_ready = !m_valid || m_ready.
REQ-021 SHALL hold m_win, m_eol and m_eof stable while m_valid && !m_ready.
REQ-022 SHALL implement FSM IDLE -> FILL on an accepted s_sof; FILL -> RUN when row reaches K-1; RUN -> DONE on acceptance of pixel IMG_W*IMG_H-1; DONE -> FILL on an accepted s_sof.
REQ-023 SHALL, in IDLE and DONE, accept and discard pixels without s_sof, keeping s_ready high when no window is pending.
REQ-024 SHALL wrap the column counter at IMG_W-1 to 0 and increment the row counter, with no gap cycle.
REQ-025 SHALL count only accepted pixels; s_valid low stalls all counters.
REQ-026 SHALL set sof_err when an accepted s_sof arrives in FILL or RUN, or when an accepted pixel in IDLE lacks s_sof after a prior frame started.
REQ-027 SHALL clear sof_err only by reset.

Reset
REQ-028 SHALL, on rst_n low, immediately force m_valid=0, m_eol=0, m_eof=0, sof_err=0, state=IDLE and counters=0; m_win is reset to 0.
REQ-029 SHALL not reset line-memory contents; any window data before K-1 lines of a new frame is never emitted.
REQ-030 SHALL, on reset mid-frame, drop the partial frame; the next valid frame starts with s_sof.

Configuration
REQ-031 SHALL honour macro WSB_SOF_RESYNC_EN: when defined, an accepted s_sof in FILL or RUN sets sof_err, aborts the current frame without emitting m_eof, and restarts FILL with that pixel as row 0/col 0.
REQ-032 SHALL, when WSB_SOF_RESYNC_EN is undefined, set sof_err on a mid-frame s_sof but ignore it and continue counting the current frame.

Structure
REQ-033 SHALL take the FSM state enum, legal-K check and index widths ($clog2 of IMG_W/IMG_H) from a shared package, edge_pkg.
REQ-034 SHALL implement each line store as sub-module line_ram (single-port, read-before-write, depth IMG_W, width PIX_W), instantiated K-1 times.

Verification
REQ-035 SHALL cover: IMG_W=8, IMG_H=6, K=3, pixel=row*8+col, continuous stream -> first window after the 19th accept is {0,1,2,8,9,10,16,17,18}, 24 windows in total, and m_eol on every 6th window.
REQ-036 SHALL cover: same frame, m_ready=0 for 5 cycles mid-line -> s_ready=0 and m_win unchanged for 5 cycles, with no window lost or duplicated.
REQ-037 SHALL cover: K=5, IMG_W=8, IMG_H=6 ramp -> first window has top row {0..4} and bottom row {32..36}, 8 windows in total, and m_eof on the 8th.
REQ-038 SHALL cover: rst_n low at pixel 30 and then a new frame -> all outputs 0 during reset, and the next frame's window sequence is identical to REQ-035.
REQ-039 SHALL cover: s_sof at pixel 20 with the macro defined -> sof_err=1, and the windows that follow correspond to the new frame origin; without the macro -> sof_err=1 and 24 windows are still produced.
REQ-040 SHALL cover: random s_valid and m_ready duty of 50% over 3 frames -> window count and contents match the reference model.
